// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner codes
// and arbitration policy codes.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ISSUE = 3'b010,
        S_WAIT  = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int POL_FIXED = 0;
    localparam int POL_RR    = 1;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// 2-way arbiter: fixed priority (data over instruction) or round-robin.
// Ports: req[0]=instruction, req[1]=data; en gates the grant; gnt one-hot.
module arb2_rr
    import mem_port_arbiter_pkg::*;
#(
    parameter int POLICY = POL_FIXED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // 1 = data was granted last. Reset to "instruction last" so the
    // first tie goes to data under either policy.
    logic last_d_q;
    logic last_d_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[1] && req[0]) begin
                if (POLICY == POL_RR && last_d_q) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        if (gnt != 2'b00) begin
            last_d_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with
// one transaction outstanding; routes read data to the owner only.
// Ports: i_* fetch channel, d_* load/store channel, m_* memory side,
// cnt_* arbitration performance counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int POLICY = POL_FIXED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    output logic [DATA_W-1:0]   i_rsp_data,
    output logic                i_rsp_valid,
    input  logic                i_rsp_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_wen,
    input  logic                d_req_ren,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_req_ready,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wen,
    output logic                m_ren,
    input  logic                m_req_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rdata_valid,
    output logic                m_rdata_ready,
    output logic [31:0]         cnt_i_grant,
    output logic [31:0]         cnt_d_grant,
    output logic [31:0]         cnt_conflict
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [31:0]         cnt_i_q, cnt_i_d;
    logic [31:0]         cnt_d_q, cnt_d_d;
    logic [31:0]         cnt_conflict_q, cnt_c_d;

    logic       d_req;
    logic       arb_en;
    logic [1:0] gnt;
    logic       in_issue;
    logic       in_wait;
    logic       own_i;
    logic       own_d;

    assign d_req    = d_req_wen | d_req_ren;
    // Gating with rst_n keeps the combinational readies low while in reset.
    assign arb_en   = (state_q == S_IDLE) & rst_n;
    assign in_issue = (state_q == S_ISSUE);
    assign in_wait  = (state_q == S_WAIT);
    assign own_i    = (owner_q == OWN_INST);
    assign own_d    = (owner_q == OWN_DATA);

    arb2_rr #(
        .POLICY (POLICY)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({d_req, i_req_valid}),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign i_req_ready   = gnt[0];
    assign d_req_ready   = gnt[1];

    assign m_addr        = addr_q;
    assign m_wdata       = wdata_q;
    assign m_wstrb       = wstrb_q;
    assign m_wen         = in_issue & wen_q;
    assign m_ren         = in_issue & ren_q;

    assign m_rdata_ready = in_wait & ((own_i & i_rsp_ready) |
                                      (own_d & d_rsp_ready));
    assign i_rsp_valid   = in_wait & own_i & m_rdata_valid;
    assign d_rsp_valid   = in_wait & own_d & m_rdata_valid;
    assign i_rsp_data    = rst_n ? m_rdata : '0;
    assign d_rsp_data    = rst_n ? m_rdata : '0;

    assign cnt_i_grant   = cnt_i_q;
    assign cnt_d_grant   = cnt_d_q;
    assign cnt_conflict  = cnt_conflict_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt[1]) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_DATA;
                    addr_d  = d_req_addr;
                    wen_d   = d_req_wen;
                    // Both strobes high is a write.
                    ren_d   = d_req_ren & ~d_req_wen;
                    wdata_d = d_req_wdata;
                    wstrb_d = d_req_wstrb;
                end else if (gnt[0]) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_INST;
                    addr_d  = i_req_addr;
                    wen_d   = 1'b0;
                    ren_d   = 1'b1;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            S_ISSUE: begin
                if (m_req_ready) begin
                    if (ren_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
            end
            S_WAIT: begin
                if (m_rdata_valid && m_rdata_ready) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        cnt_i_d = cnt_i_q + 32'(gnt[0]);
        cnt_d_d = cnt_d_q + 32'(gnt[1]);
        cnt_c_d = cnt_conflict_q + 32'(arb_en & d_req & i_req_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            owner_q        <= OWN_NONE;
            addr_q         <= '0;
            wen_q          <= 1'b0;
            ren_q          <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            cnt_i_q        <= '0;
            cnt_d_q        <= '0;
            cnt_conflict_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            wen_q          <= wen_d;
            ren_q          <= ren_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            cnt_i_q        <= cnt_i_d;
            cnt_d_q        <= cnt_d_d;
            cnt_conflict_q <= cnt_c_d;
        end
    end

endmodule
